// File: rtl/seq4_pkg.sv
// Shared definitions for the 4-bit custom-sequence counter and its decoder:
// sequence length, code table, code/position lookups and decoder states.
package seq4_pkg;

    localparam int SEQ_LEN = 14;
    localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

    localparam logic [3:0] CODE_TABLE [SEQ_LEN] = '{
        4'd8, 4'd7, 4'd11, 4'd4, 4'd9, 4'd2, 4'd5,
        4'd12, 4'd6, 4'd3, 4'd15, 4'd1, 4'd14, 4'd13
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] idx;
    } lookup_t;

    // Codes 0 and 10 never appear in the table, so they come back flagged illegal.
    function automatic lookup_t code2idx(input logic [3:0] code);
        lookup_t r;
        r.illegal = 1'b1;
        r.idx     = 4'd0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (CODE_TABLE[i] == code) begin
                r.illegal = 1'b0;
                r.idx     = 4'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] idx2code(input logic [3:0] idx);
        logic [3:0] code;
        code = 4'd0;
        if (idx <= LAST_IDX) begin
            code = CODE_TABLE[idx];
        end
        return code;
    endfunction

    function automatic logic [3:0] next_idx(input logic [3:0] idx);
        return (idx >= LAST_IDX) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/seq4_code_lut.sv
// Combinational lookup between counter codes and sequence positions,
// in both directions at once.
module seq4_code_lut
    import seq4_pkg::*;
(
    input  logic [3:0] code_in,
    input  logic [3:0] idx_in,
    output logic [3:0] idx_out,
    output logic       illegal_out,
    output logic [3:0] code_out
);

    lookup_t hit;

    assign hit         = code2idx(code_in);
    assign idx_out     = hit.idx;
    assign illegal_out = hit.illegal;
    assign code_out    = idx2code(idx_in);

endmodule

// File: rtl/seq4_decoder.sv
// Receive-side decoder/monitor for the 4-bit custom-sequence counter.
// Optional feature: define SEQ4_DECODER_HOLD_EN to treat a repeated code as a hold.
module seq4_decoder
    import seq4_pkg::*;
#(
    parameter int LOCK_N = 2,
    parameter int MISS_N = 3,
    parameter int ERRW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [3:0]      count_in,
    output logic            locked,
    output logic            idx_vld,
    output logic [3:0]      idx,
    output logic            err,
    output logic            illegal,
    output logic [ERRW-1:0] err_cnt
);

`ifdef SEQ4_DECODER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam logic [3:0] LOCK_TH = 4'(LOCK_N);
    localparam logic [3:0] MISS_TH = 4'(MISS_N);
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};
    localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [3:0]      exp_q, exp_d;
    logic [2:0]      run_q, run_d;
    logic [2:0]      miss_q, miss_d;
    logic [3:0]      last_q, last_d;
    logic [3:0]      idx_q, idx_d;
    logic            locked_q, locked_d;
    logic            idx_vld_q, idx_vld_d;
    logic            err_q, err_d;
    logic            illegal_q, illegal_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic [3:0] in_idx;
    logic       in_illegal;
    logic [3:0] in_code_nc;
    logic [3:0] exp_code;
    logic [3:0] exp_idx_nc;
    logic       exp_illegal_nc;
    logic       unused_lut;

    seq4_code_lut u_in_lut (
        .code_in     (count_in),
        .idx_in      (4'd0),
        .idx_out     (in_idx),
        .illegal_out (in_illegal),
        .code_out    (in_code_nc)
    );

    seq4_code_lut u_exp_lut (
        .code_in     (4'd0),
        .idx_in      (exp_q),
        .idx_out     (exp_idx_nc),
        .illegal_out (exp_illegal_nc),
        .code_out    (exp_code)
    );

    assign unused_lut = ^{in_code_nc, exp_idx_nc, exp_illegal_nc};

    logic       is_hold;
    logic       is_match;
    logic [3:0] run_inc;
    logic [3:0] miss_inc;

    // exp_code is always a legal table entry, so an illegal input can never match.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        run_d     = run_q;
        miss_d    = miss_q;
        last_d    = last_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        illegal_d = 1'b0;
        run_inc   = {1'b0, run_q} + 4'd1;
        miss_inc  = {1'b0, miss_q} + 4'd1;
        is_hold   = HOLD_EN && (state_q != HUNT) && (count_in == last_q);
        is_match  = (count_in == exp_code);

        if (valid) begin
            illegal_d = in_illegal;
            last_d    = count_in;
            case (state_q)
                HUNT: begin
                    if (!in_illegal) begin
                        idx_d   = in_idx;
                        exp_d   = next_idx(in_idx);
                        run_d   = 3'd1;
                        miss_d  = 3'd0;
                        state_d = (LOCK_N == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_hold) begin
                        state_d = VERIFY;
                    end else if (is_match) begin
                        idx_d = exp_q;
                        exp_d = next_idx(exp_q);
                        run_d = run_inc[2:0];
                        if (run_inc >= LOCK_TH) begin
                            state_d = LOCKED;
                            miss_d  = 3'd0;
                        end
                    end else if (!in_illegal) begin
                        idx_d = in_idx;
                        exp_d = next_idx(in_idx);
                        run_d = 3'd1;
                    end else begin
                        state_d = HUNT;
                        run_d   = 3'd0;
                        miss_d  = 3'd0;
                    end
                end
                LOCKED: begin
                    if (!is_hold) begin
                        // Flywheel: position keeps advancing even on a bad sample.
                        idx_d = exp_q;
                        exp_d = next_idx(exp_q);
                        if (is_match) begin
                            miss_d = 3'd0;
                        end else begin
                            err_d = 1'b1;
                            if (err_cnt_q != ERR_MAX) begin
                                err_cnt_d = err_cnt_q + ERR_ONE;
                            end
                            if (miss_inc >= MISS_TH) begin
                                state_d = HUNT;
                                miss_d  = 3'd0;
                                run_d   = 3'd0;
                            end else begin
                                miss_d = miss_inc[2:0];
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d  = (state_d == LOCKED);
        idx_vld_d = (state_d != HUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HUNT;
            exp_q     <= 4'd0;
            run_q     <= 3'd0;
            miss_q    <= 3'd0;
            last_q    <= 4'd0;
            idx_q     <= 4'd0;
            locked_q  <= 1'b0;
            idx_vld_q <= 1'b0;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            locked_q  <= locked_d;
            idx_vld_q <= idx_vld_d;
            err_q     <= err_d;
            illegal_q <= illegal_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign idx_vld = idx_vld_q;
    assign idx     = idx_q;
    assign err     = err_q;
    assign illegal = illegal_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seq4_decoder.sv
// Self-checking bench for seq4_decoder: directed scenarios then random stimulus,
// all compared against a sequence-level reference model kept in this file.
module tb_seq4_decoder;

    localparam int LOCK_N = 2;
    localparam int MISS_N = 3;
    localparam int ERRW   = 4;
    localparam int CNT_MAX = (1 << ERRW) - 1;

`ifdef SEQ4_DECODER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            valid;
    logic [3:0]      count_in;
    logic            locked;
    logic            idx_vld;
    logic [3:0]      idx;
    logic            err;
    logic            illegal;
    logic [ERRW-1:0] err_cnt;

    int checkCount = 0;
    int errorCount = 0;

    int seqTab [14] = '{8, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15, 1, 14, 13};

    // Reference model state, kept in plain integers.
    int mTrack, mLocked, mIdx, mExp, mRun, mMiss, mCnt, mLast, mErr, mIll;

    seq4_decoder #(
        .LOCK_N (LOCK_N),
        .MISS_N (MISS_N),
        .ERRW   (ERRW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .count_in (count_in),
        .locked   (locked),
        .idx_vld  (idx_vld),
        .idx      (idx),
        .err      (err),
        .illegal  (illegal),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int findPos(input int code);
        for (int i = 0; i < 14; i++) begin
            if (seqTab[i] == code) return i;
        end
        return -1;
    endfunction

    function automatic void modelReset();
        mTrack = 0; mLocked = 0; mIdx = 0; mExp = 0; mRun = 0;
        mMiss = 0; mCnt = 0; mLast = 0; mErr = 0; mIll = 0;
    endfunction

    function automatic void modelStep(input bit v, input int c);
        int p;
        mErr = 0;
        mIll = 0;
        if (!v) return;
        p = findPos(c);
        mIll = (p < 0);
        if (!mTrack) begin
            if (p >= 0) begin
                mIdx = p; mExp = (p + 1) % 14; mRun = 1; mMiss = 0;
                mTrack = 1; mLocked = (LOCK_N == 1);
            end
        end else if (HOLD && c == mLast) begin
            // repeated code: nothing moves
        end else if (!mLocked) begin
            if (c == seqTab[mExp]) begin
                mIdx = mExp; mExp = (mExp + 1) % 14; mRun++;
                if (mRun >= LOCK_N) begin
                    mLocked = 1; mMiss = 0;
                end
            end else if (p >= 0) begin
                mIdx = p; mExp = (p + 1) % 14; mRun = 1;
            end else begin
                mTrack = 0; mRun = 0; mMiss = 0;
            end
        end else begin
            if (c != seqTab[mExp]) begin
                mErr = 1;
                if (mCnt < CNT_MAX) mCnt++;
                mMiss++;
            end else begin
                mMiss = 0;
            end
            mIdx = mExp; mExp = (mExp + 1) % 14;
            if (mMiss >= MISS_N) begin
                mTrack = 0; mLocked = 0; mMiss = 0; mRun = 0;
            end
        end
        mLast = c;
    endfunction

    task automatic compareAll();
        checkOutput("locked", locked, mLocked);
        checkOutput("idx_vld", idx_vld, mTrack);
        checkOutput("idx", idx, mIdx);
        checkOutput("err", err, mErr);
        checkOutput("illegal", illegal, mIll);
        checkOutput("err_cnt", err_cnt, mCnt);
    endtask

    task automatic applyStimulus(input bit v, input int c);
        valid    = v;
        count_in = 4'(c);
        @(posedge clk);
        #1;
        modelStep(v, c);
        compareAll();
    endtask

    // Reset is applied with a valid sample present; reset must win.
    task automatic doReset();
        reset    = 1'b1;
        valid    = 1'b1;
        count_in = 4'd8;
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        modelReset();
        compareAll();
    endtask

    initial begin
        int r;
        reset    = 1'b1;
        valid    = 1'b0;
        count_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        // Lock on 8,7, then walk to code 4 and inject a wrong code.
        applyStimulus(1, 8);
        applyStimulus(1, 7);
        checkOutput("plan_lock_locked", locked, 1);
        checkOutput("plan_lock_idx", idx, 1);
        applyStimulus(1, 11);
        applyStimulus(1, 4);
        applyStimulus(1, 5);
        checkOutput("plan_flywheel_err", err, 1);
        checkOutput("plan_flywheel_idx", idx, 4);
        applyStimulus(1, 2);
        applyStimulus(1, 5);
        checkOutput("plan_recover_idx", idx, 6);

        // Walk through the wrap-around and idle cycles.
        foreach (seqTab[i]) if (i >= 7) applyStimulus(1, seqTab[i]);
        applyStimulus(1, 8);
        applyStimulus(0, 3);
        applyStimulus(1, 7);
        checkOutput("plan_wrap_idx", idx, 1);

        // Three misses (the first is also illegal) drop lock; 10 in HUNT is illegal.
        applyStimulus(1, 0);
        checkOutput("plan_illegal_err", illegal & err, 1);
        applyStimulus(1, 3);
        applyStimulus(1, 6);
        checkOutput("plan_loss_locked", locked, 0);
        applyStimulus(1, 10);
        checkOutput("plan_hunt_illegal", illegal, 1);
        applyStimulus(1, 4);
        checkOutput("plan_verify_vld", idx_vld, 1);
        applyStimulus(1, 2);
        applyStimulus(1, 9);

        // Repeated code while locked at code 4.
        doReset();
        applyStimulus(1, 11);
        applyStimulus(1, 4);
        applyStimulus(1, 4);
        checkOutput("plan_repeat_idx", idx, HOLD ? 3 : 4);

        // Drive enough misses to saturate the error counter.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, seqTab[k]);
            applyStimulus(1, seqTab[k + 1]);
            applyStimulus(1, 0);
            applyStimulus(1, 10);
            applyStimulus(1, 0);
        end
        checkOutput("plan_saturate", err_cnt, CNT_MAX);

        // Random stimulus, biased toward the expected next code so lock is reached.
        doReset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) doReset();
            else if (r < 12) applyStimulus(0, $urandom_range(0, 15));
            else if (r < 22) applyStimulus(1, $urandom_range(0, 15));
            else if (r < 27) applyStimulus(1, mLast);
            else if (mTrack != 0) applyStimulus(1, seqTab[mExp]);
            else applyStimulus(1, seqTab[$urandom_range(0, 13)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
